// File: rtl/pipe_ctrl.sv
// pipe_ctrl: stall/flush sequencer for the 5-stage core (drain, hazards, dmem watchdog).
// Define PIPE_CTRL_PERF_EN to build the saturating stall/flush performance counters.
module pipe_ctrl #(
  parameter int INIT_CYCLES = 2,
  parameter int TIMEOUT     = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        MemRead_E,
  input  logic [4:0]  rd_E,
  input  logic [4:0]  rs1_D,
  input  logic [4:0]  rs2_D,
  input  logic        PCSrc_E,
  input  logic        dmem_req_M,
  input  logic        dmem_ack,
  input  logic        err_clr,
  output logic        Stall_F,
  output logic        Stall_D,
  output logic        Stall_E,
  output logic        Stall_M,
  output logic        Flush_D,
  output logic        Flush_E,
  output logic        Flush_W,
  output logic        mem_err,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);
  localparam int WW = $clog2(TIMEOUT);
  localparam int IW = INIT_CYCLES > 1 ? $clog2(INIT_CYCLES) : 1;
  localparam logic [1:0] S_INIT = 2'd0, S_RUN = 2'd1, S_WAIT = 2'd2, S_ERR = 2'd3;
  logic [1:0]    state_q, state_d;
  logic [IW-1:0] init_cnt_q, init_cnt_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic mem_stall, load_use, hold, free, redirect, lu, init;
  always_comb begin
    mem_stall = dmem_req_M & ~dmem_ack;
    load_use  = MemRead_E & (rd_E != 5'd0) & ((rd_E == rs1_D) | (rd_E == rs2_D));
    init      = state_q == S_INIT;
    hold      = (state_q == S_RUN & mem_stall) | (state_q == S_WAIT & ~dmem_ack) | state_q == S_ERR;
    // an ack while waiting releases in the same cycle and falls through to RUN priorities
    free      = (state_q == S_RUN & ~mem_stall) | (state_q == S_WAIT & dmem_ack);
    redirect  = free & PCSrc_E;
    lu        = free & ~PCSrc_E & load_use;
    Stall_F   = hold | lu | init;
    Stall_D   = hold | lu;
    Stall_E   = hold;
    Stall_M   = hold;
    Flush_W   = hold;
    Flush_D   = init | redirect;
    Flush_E   = init | redirect | lu;
    mem_err   = state_q == S_ERR;
  end
  always_comb begin
    state_d    = state_q;
    init_cnt_d = init_cnt_q;
    wait_cnt_d = wait_cnt_q;
    case (state_q)
      S_INIT: begin
        init_cnt_d = init_cnt_q == IW'(INIT_CYCLES - 1) ? '0 : init_cnt_q + 1'b1;
        state_d    = init_cnt_q == IW'(INIT_CYCLES - 1) ? S_RUN : S_INIT;
      end
      S_RUN: begin
        state_d    = mem_stall ? S_WAIT : S_RUN;
        wait_cnt_d = mem_stall ? WW'(1) : wait_cnt_q;
      end
      S_WAIT: begin
        state_d    = dmem_ack ? S_RUN : (wait_cnt_q == WW'(TIMEOUT - 1) ? S_ERR : S_WAIT);
        wait_cnt_d = dmem_ack ? wait_cnt_q : wait_cnt_q + 1'b1;
      end
      default: begin
        state_d    = err_clr ? S_INIT : S_ERR;
        init_cnt_d = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_INIT;
      init_cnt_q <= '0;
      wait_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      init_cnt_q <= init_cnt_d;
      wait_cnt_q <= wait_cnt_d;
    end
  end
`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] stall_cnt_q, flush_cnt_q;
  logic act;
  assign act = state_q == S_RUN | state_q == S_WAIT;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      if (act & Stall_F & ~&stall_cnt_q) stall_cnt_q <= stall_cnt_q + 32'd1;
      if (act & Flush_D & ~&flush_cnt_q) flush_cnt_q <= flush_cnt_q + 32'd1;
    end
  end
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed checks of pipe_ctrl with INIT_CYCLES=2, TIMEOUT=4.
module tb_pipe_ctrl;
  logic clk = 0, rst_n = 0;
  logic MemRead_E = 0, PCSrc_E = 0, dmem_req_M = 0, dmem_ack = 0, err_clr = 0;
  logic [4:0] rd_E = 0, rs1_D = 0, rs2_D = 0;
  logic Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W, mem_err;
  logic [31:0] stall_cnt, flush_cnt;
  int errors = 0, checks = 0;
  // ctl = {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W}
  wire [6:0] ctl = {Stall_F, Stall_D, Stall_E, Stall_M, Flush_D, Flush_E, Flush_W};
  localparam logic [6:0] INIT_V = 7'b1000110, HOLD_V = 7'b1111001, LU_V = 7'b1100010;
  localparam logic [6:0] RD_V = 7'b0000110, NONE_V = 7'b0000000;
`ifdef PIPE_CTRL_PERF_EN
  localparam logic [31:0] EXP_STALLS = 32'd1, EXP_FLUSHES = 32'd1;
`else
  localparam logic [31:0] EXP_STALLS = 32'd0, EXP_FLUSHES = 32'd0;
`endif

  pipe_ctrl #(.INIT_CYCLES(2), .TIMEOUT(4)) dut (
    .clk(clk), .rst_n(rst_n), .MemRead_E(MemRead_E), .rd_E(rd_E), .rs1_D(rs1_D),
    .rs2_D(rs2_D), .PCSrc_E(PCSrc_E), .dmem_req_M(dmem_req_M), .dmem_ack(dmem_ack),
    .err_clr(err_clr), .Stall_F(Stall_F), .Stall_D(Stall_D), .Stall_E(Stall_E),
    .Stall_M(Stall_M), .Flush_D(Flush_D), .Flush_E(Flush_E), .Flush_W(Flush_W),
    .mem_err(mem_err), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    MemRead_E = 0; PCSrc_E = 0; dmem_req_M = 0; dmem_ack = 0; err_clr = 0;
    rd_E = 0; rs1_D = 0; rs2_D = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 0;
    #13;
    checks++; if (ctl !== INIT_V) begin errors++; $display("FAIL reset_ctl got=%b exp=%b", ctl, INIT_V); end
    checks++; if (mem_err !== 1'b0) begin errors++; $display("FAIL reset_mem_err got=%b exp=0", mem_err); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL reset_stall_cnt got=%0d exp=0", stall_cnt); end
    checks++; if (flush_cnt !== 32'd0) begin errors++; $display("FAIL reset_flush_cnt got=%0d exp=0", flush_cnt); end
    step();
    rst_n = 1;
    #1;
    checks++; if (ctl !== INIT_V) begin errors++; $display("FAIL drain_c0 got=%b exp=%b", ctl, INIT_V); end
    step();
    checks++; if (ctl !== INIT_V) begin errors++; $display("FAIL drain_c1 got=%b exp=%b", ctl, INIT_V); end
    step();
    checks++; if (ctl !== NONE_V) begin errors++; $display("FAIL drain_c2_run got=%b exp=%b", ctl, NONE_V); end
  endtask

  task automatic test_load_use();
    MemRead_E = 1; rd_E = 5; rs2_D = 5; rs1_D = 1;
    #1;
    checks++; if (ctl !== LU_V) begin errors++; $display("FAIL load_use got=%b exp=%b", ctl, LU_V); end
    step();
    clear_inputs();
    #1;
    checks++; if (ctl !== NONE_V) begin errors++; $display("FAIL load_use_one_bubble got=%b exp=%b", ctl, NONE_V); end
    MemRead_E = 1; rd_E = 0; rs1_D = 0; rs2_D = 0;
    #1;
    checks++; if (ctl !== NONE_V) begin errors++; $display("FAIL load_use_x0 got=%b exp=%b", ctl, NONE_V); end
    step();
    clear_inputs();
  endtask

  task automatic test_redirect_load_use();
    PCSrc_E = 1; MemRead_E = 1; rd_E = 3; rs1_D = 3;
    #1;
    checks++; if (ctl !== RD_V) begin errors++; $display("FAIL redirect_over_lu got=%b exp=%b", ctl, RD_V); end
    step();
    clear_inputs();
  endtask

  task automatic test_perf();
    #1;
    checks++; if (stall_cnt !== EXP_STALLS) begin errors++; $display("FAIL perf_stall_cnt got=%0d exp=%0d", stall_cnt, EXP_STALLS); end
    checks++; if (flush_cnt !== EXP_FLUSHES) begin errors++; $display("FAIL perf_flush_cnt got=%0d exp=%0d", flush_cnt, EXP_FLUSHES); end
  endtask

  task automatic test_mem_wait();
    dmem_req_M = 1;
    #1;
    checks++; if (ctl !== HOLD_V) begin errors++; $display("FAIL memwait_c1 got=%b exp=%b", ctl, HOLD_V); end
    step();
    checks++; if (ctl !== HOLD_V) begin errors++; $display("FAIL memwait_c2 got=%b exp=%b", ctl, HOLD_V); end
    step();
    dmem_ack = 1; PCSrc_E = 1;
    #1;
    checks++; if (ctl !== RD_V) begin errors++; $display("FAIL memwait_ack_redirect got=%b exp=%b", ctl, RD_V); end
    step();
    clear_inputs();
    #1;
    checks++; if (ctl !== NONE_V) begin errors++; $display("FAIL memwait_back_run got=%b exp=%b", ctl, NONE_V); end
  endtask

  task automatic test_timeout();
    dmem_req_M = 1;
    for (int c = 1; c <= 4; c++) begin
      #1;
      checks++; if (ctl !== HOLD_V || mem_err !== 1'b0) begin errors++; $display("FAIL timeout_c%0d got=%b/%b exp=%b/0", c, ctl, mem_err, HOLD_V); end
      step();
    end
    dmem_req_M = 0; dmem_ack = 1;
    #1;
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL timeout_err got=%b exp=1", mem_err); end
    checks++; if (ctl !== HOLD_V) begin errors++; $display("FAIL timeout_err_ctl got=%b exp=%b", ctl, HOLD_V); end
    step();
    dmem_ack = 0; err_clr = 1;
    #1;
    checks++; if (mem_err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%b exp=1", mem_err); end
    step();
    err_clr = 0;
    #1;
    checks++; if (ctl !== INIT_V || mem_err !== 1'b0) begin errors++; $display("FAIL errclr_init0 got=%b/%b exp=%b/0", ctl, mem_err, INIT_V); end
    step();
    checks++; if (ctl !== INIT_V) begin errors++; $display("FAIL errclr_init1 got=%b exp=%b", ctl, INIT_V); end
    step();
    checks++; if (ctl !== NONE_V) begin errors++; $display("FAIL errclr_run got=%b exp=%b", ctl, NONE_V); end
  endtask

  task automatic test_ack_at_limit();
    dmem_req_M = 1;
    step(); step(); step();
    dmem_ack = 1;
    #1;
    checks++; if (ctl !== NONE_V) begin errors++; $display("FAIL ack_c4_release got=%b exp=%b", ctl, NONE_V); end
    step();
    clear_inputs();
    #1;
    checks++; if (mem_err !== 1'b0 || ctl !== NONE_V) begin errors++; $display("FAIL ack_c4_no_err got=%b/%b exp=0/%b", mem_err, ctl, NONE_V); end
  endtask

  task automatic test_async_reset();
    dmem_req_M = 1;
    step(); step();
    #2;
    rst_n = 0;
    #1;
    checks++; if (ctl !== INIT_V || mem_err !== 1'b0) begin errors++; $display("FAIL async_reset_wait got=%b/%b exp=%b/0", ctl, mem_err, INIT_V); end
    checks++; if (stall_cnt !== 32'd0) begin errors++; $display("FAIL async_reset_cnt got=%0d exp=0", stall_cnt); end
    clear_inputs();
    step();
    rst_n = 1;
  endtask

  initial begin
    test_reset();
    test_load_use();
    test_redirect_load_use();
    test_perf();
    test_mem_wait();
    test_timeout();
    test_ack_at_limit();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_ctrl.md
# pipe_ctrl

Pipeline control sequencer for the 5-stage core. It sits beside the forwarding unit and drives the per-stage stall and flush controls. It resolves three hazards in fixed priority: a data-memory wait, an EX-stage redirect, and a load-use dependency. It also owns a post-reset drain sequence and a data-memory timeout watchdog with a sticky error.

## Interface
Parameters:
- INIT_CYCLES, 2: cycles the pipeline is held flushed after reset or error clear (≥1).
- TIMEOUT, 64: maximum consecutive memory-stall cycles before error (≥2).

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- MemRead_E  in  1  instruction in EX is a load
- rd_E  in  5  destination register of EX instruction
- rs1_D  in  5  source 1 of ID instruction
- rs2_D  in  5  source 2 of ID instruction
- PCSrc_E  in  1  taken branch/jump resolved in EX
- dmem_req_M  in  1  MEM-stage instruction accesses data memory
- dmem_ack  in  1  data memory completes the access this cycle
- err_clr  in  1  clears ERR state
- Stall_F, Stall_D, Stall_E, Stall_M  out  1 each  hold the stage register
- Flush_D, Flush_E, Flush_W  out  1 each  load a bubble into the stage register
- mem_err  out  1  sticky timeout error
- stall_cnt, flush_cnt  out  32 each  performance counters (see Configuration)

## Operation
State machine with states INIT, RUN, MEM_WAIT and ERR. A wait counter, wait_cnt, is $clog2(TIMEOUT) bits wide. An init counter, init_cnt, is also kept.

- **INIT:**
  - Outputs: Stall_F=1, Flush_D=1, Flush_E=1; all other stalls and flushes are 0.
  - init_cnt increments each cycle.
  - Transitions to RUN on the edge where init_cnt==INIT_CYCLES-1.
- **RUN:** outputs are combinational, evaluated in this priority order:
  1. mem_stall = dmem_req_M & ~dmem_ack:
     - Stall_F, Stall_D, Stall_E, Stall_M = 1; Flush_W=1.
     - Next state is MEM_WAIT; wait_cnt is loaded with 1.
  2. Else if PCSrc_E: Flush_D=1, Flush_E=1. Any load-use hazard is ignored, because the ID instruction is squashed.
  3. Else load_use = MemRead_E & (rd_E!=0) & (rd_E==rs1_D | rd_E==rs2_D): Stall_F=1, Stall_D=1, Flush_E=1.
  4. Else all controls are 0.
- **MEM_WAIT:**
  - While ~dmem_ack, the outputs are the same as for mem_stall.
  - If additionally wait_cnt==TIMEOUT-1, the next state is ERR; otherwise wait_cnt increments.
  - In the cycle dmem_ack=1, outputs are evaluated exactly as in RUN priorities 2–4 (zero-latency release), and the next state is RUN.
- **ERR:**
  - Outputs: Stall_F, Stall_D, Stall_E, Stall_M = 1; Flush_W=1; mem_err=1.
  - err_clr=1 moves the machine to INIT, with init_cnt=0 and mem_err cleared on the same edge.
- mem_err is 1 only in ERR.
- dmem_ack without dmem_req_M is ignored.
- err_clr outside ERR is ignored.

## Timing
- Reset: state=INIT, init_cnt=0, wait_cnt=0, counters=0.
  - While rst_n=0, outputs equal the INIT values: Stall_F=1, Flush_D=1, Flush_E=1, everything else 0, mem_err=0.
- First RUN cycle is cycle INIT_CYCLES after reset release.
- Hazard outputs in RUN have zero latency; they are combinational from the inputs.
- A load-use hazard costs exactly 1 bubble.
- A redirect costs 2 squashed instructions.
- Memory stall with ack in stalled cycle k: stalls are released in cycle k, so k-1 cycles are lost.
- Timeout: ERR is entered on the edge ending the TIMEOUT-th consecutive stalled cycle without ack. An ack in that TIMEOUT-th cycle completes normally.
- Reset asserted mid-MEM_WAIT or mid-ERR: immediate asynchronous return to INIT values.

## Configuration
- PIPE_CTRL_PERF_EN defined:
  - stall_cnt increments on every cycle with Stall_F=1 in RUN or MEM_WAIT.
  - flush_cnt increments on every RUN/MEM_WAIT cycle with Flush_D=1.
  - Both are 32-bit, saturate at 0xFFFF_FFFF, and reset to 0.
- Undefined: both counters are tied to 0 and no counter flops exist.

## Test plan
- **Reset drain:** INIT_CYCLES=2, release rst_n.
  - Cycles 0–1: Stall_F=Flush_D=Flush_E=1.
  - Cycle 2: all 0.
- **Load-use:** MemRead_E=1, rd_E=5, rs2_D=5, in RUN → Stall_F=Stall_D=Flush_E=1 for 1 cycle.
  - With rd_E=0 → no stall.
- **Redirect + load-use same cycle:** PCSrc_E=1, MemRead_E=1, rd_E=rs1_D=3 → Flush_D=Flush_E=1, Stall_F=0.
- **Memory wait:** dmem_req_M=1, ack arriving in the 3rd cycle → stalls high for 2 cycles and low in the ack cycle.
  - A pending PCSrc_E yields Flush_D/E in the ack cycle.
- **Timeout:** TIMEOUT=4, ack never arrives → stalled cycles 1–4, mem_err=1 from cycle 5.
  - Ack in cycle 4 instead → mem_err stays 0.
  - err_clr=1 → INIT then RUN.
- **Perf counters** (PIPE_CTRL_PERF_EN defined):
  - 1 load-use plus 1 redirect → stall_cnt=1, flush_cnt=1.
  - Without the macro, both read 0.
